// File: rtl/cocofdc_pkg.sv
// Shared opcodes, FSM states and constants for the SPI-to-cartridge-memory bridge.
package cocofdc_pkg;

  localparam logic [7:0] CMD_SETADDR = 8'h01;
  localparam logic [7:0] CMD_WRITE   = 8'h02;
  localparam logic [7:0] CMD_READ    = 8'h03;
  localparam logic [7:0] CMD_REQ     = 8'h04;
  localparam logic [7:0] CMD_REL     = 8'h05;
  localparam logic [7:0] CMD_STAT    = 8'h06;
  localparam logic [7:0] NOWN_FILL   = 8'hEE;

  typedef enum logic [2:0] {IDLE, ADDR, WLEN, WDATA, RLEN, RDATA} state_t;

  // A length byte of zero encodes a full 256-byte burst.
  function automatic logic [8:0] burst_len(input logic [7:0] b);
    return (b == 8'h00) ? 9'd256 : {1'b0, b};
  endfunction

endpackage

// File: rtl/spi_mem_cycle.sv
// Timed strobe generator: one write (WE_CYCLES) or read (RD_LAT) cycle per start.
module spi_mem_cycle #(
  parameter int RD_LAT    = 2,
  parameter int WE_CYCLES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic rw,
  input  logic abort,
  output logic busy,
  output logic mem_we,
  output logic mem_oe,
  output logic done
);
  localparam int MAXC = (RD_LAT > WE_CYCLES) ? RD_LAT : WE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;

  // done marks the last strobe cycle so the owner can sample read data on the same edge.
  assign done = busy & (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
      cnt    <= '0;
    end else if (abort || done) begin
      busy   <= 1'b0;
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
    end else if (start) begin
      busy   <= 1'b1;
      mem_we <= rw;
      mem_oe <= ~rw;
      cnt    <= rw ? CW'(WE_CYCLES - 1) : CW'(RD_LAT - 1);
    end
  end

endmodule

// File: rtl/spi_mem_bridge.sv
// Decodes SPI command bytes and drives burst reads/writes on the cartridge memory bus.
module spi_mem_bridge
  import cocofdc_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int ADDR_BYTES = 2,
  parameter int RD_LAT     = 2,
  parameter int WE_CYCLES  = 6
) (
  input  logic              clock_50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              spi_control,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic              mem_oe,
  output logic              busy
);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [8:0]        count, cnt_dec, count_n;
  logic [3:0]        abyte;
  logic              ovr, nown, burst_nown;
  logic              start, rw, own, cyc_live;
  logic              cyc_busy, cyc_we, cyc_oe, cyc_done;

  spi_mem_cycle #(.RD_LAT(RD_LAT), .WE_CYCLES(WE_CYCLES)) u_cycle (
    .clk(clock_50), .reset(reset), .start(start), .rw(rw), .abort(~spi_control),
    .busy(cyc_busy), .mem_we(cyc_we), .mem_oe(cyc_oe), .done(cyc_done)
  );

  assign mem_addr = addr;
  assign mem_we   = cyc_we & spi_control;
  assign mem_oe   = cyc_oe & spi_control;
  assign busy     = cyc_busy;

  always_comb begin
    own      = spi_control & ~burst_nown;
    cnt_dec  = (count != 9'd0) ? count - 9'd1 : 9'd0;
    count_n  = rx_valid ? cnt_dec : count;
    cyc_live = cyc_busy & ~cyc_done & spi_control;
    start    = 1'b0;
    rw       = 1'b0;
    case (state)
      WDATA: if (rx_valid && !cyc_busy && count != 9'd0 && own) begin
        start = 1'b1;
        rw    = 1'b1;
      end
      RLEN:  start = rx_valid & spi_control;
      // The final dummy byte only closes the burst; it does not fetch past it.
      RDATA: start = rx_valid & ~cyc_busy & (count > 9'd1) & own;
      default: ;
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      count       <= '0;
      abyte       <= '0;
      tx_data     <= 8'h00;
      bus_req     <= 1'b0;
      spi_control <= 1'b0;
      ovr         <= 1'b0;
      nown        <= 1'b0;
      burst_nown  <= 1'b0;
      mem_wdata   <= 8'h00;
    end else begin
      spi_control <= bus_req & bus_gnt;
      // Grant lost under an in-flight strobe: finish the burst without the bus.
      if (cyc_busy && !spi_control) begin
        nown       <= 1'b1;
        burst_nown <= 1'b1;
        if (cyc_oe) tx_data <= NOWN_FILL;
      end
      if (cyc_done && spi_control) begin
        addr <= addr + ADDR_W'(1);
        if (cyc_oe) tx_data <= mem_rdata;
      end
      case (state)
        IDLE: if (rx_valid) begin
          case (rx_data)
            CMD_SETADDR: begin state <= ADDR; abyte <= '0; end
            CMD_WRITE:   state <= WLEN;
            CMD_READ:    state <= RLEN;
            CMD_REQ:     bus_req <= 1'b1;
            CMD_REL:     bus_req <= 1'b0;
            CMD_STAT: begin
              tx_data <= {spi_control, bus_req, ovr, nown, 4'b0000};
              ovr     <= 1'b0;
              nown    <= 1'b0;
            end
            default: ;
          endcase
        end
        ADDR: if (rx_valid) begin
          addr <= ADDR_W'({addr, rx_data});
          if (abyte == 4'(ADDR_BYTES - 1)) state <= IDLE;
          else abyte <= abyte + 4'd1;
        end
        WLEN, RLEN: if (rx_valid) begin
          count      <= burst_len(rx_data);
          burst_nown <= ~spi_control;
          if (!spi_control) nown <= 1'b1;
          if (state == RLEN && !spi_control) tx_data <= NOWN_FILL;
          state <= (state == WLEN) ? WDATA : RDATA;
        end
        default: begin
          if (rx_valid) begin
            // Overrun bytes still count so the host's framing stays aligned.
            count <= cnt_dec;
            if (cyc_busy) ovr <= 1'b1;
            else if (start) begin
              if (state == WDATA) mem_wdata <= rx_data;
            end else if (state == WDATA || cnt_dec != 9'd0) begin
              if (state == RDATA) tx_data <= NOWN_FILL;
              if (!spi_control) begin
                nown       <= 1'b1;
                burst_nown <= 1'b1;
              end
            end
          end
          if (count_n == 9'd0 && !cyc_live && !start) state <= IDLE;
        end
      endcase
    end
  end

endmodule
